// File: rtl/native_bus_pkg.sv
// Shared types and constants for the native valid/ready bus arbiter.
//   rstate_t : read-side FSM states
//   wstate_t : write-side FSM states
//   MST_I / MST_D : master indices (instruction / data port)
package native_bus_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rstate_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_XFER = 1'b1
  } wstate_t;

  localparam logic MST_I = 1'b0;
  localparam logic MST_D = 1'b1;

endpackage

// File: rtl/native_rr_arbiter.sv
// Two-way grant decision for one bus direction.
// Policy is selected by NATIVE_ARB_ROUND_ROBIN_EN:
//   defined     : a tie goes to the master that did not win last
//   not defined : a tie always goes to MST_D (last is ignored)
// Ports:
//   req         in  [1:0] request per master, indexed by MST_I / MST_D
//   enable      in        arbitration allowed this cycle
//   last        in        index of the previous winner
//   grant_valid out       a grant is being made this cycle
//   grant       out       index of the winning master
module native_rr_arbiter
  import native_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant
);

  logic tie_winner;

`ifdef NATIVE_ARB_ROUND_ROBIN_EN
  assign tie_winner = (last == MST_D) ? MST_I : MST_D;
`else
  logic unused_last;
  assign unused_last = last;
  assign tie_winner  = MST_D;
`endif

  assign grant_valid = enable & (|req);

  always_comb begin
    case (req)
      2'b01:   grant = MST_I;
      2'b10:   grant = MST_D;
      2'b11:   grant = tie_winner;
      default: grant = MST_D;
    endcase
  end

endmodule

// File: rtl/native_bus_arbiter.sv
// Two-master (I, D) to one-slave (m) arbiter for the native valid/ready bus.
// Reads and writes are arbitrated independently with one outstanding
// transaction per direction; read data returns to the master that issued
// the address. Optional macro: NATIVE_ARB_ROUND_ROBIN_EN (round-robin ties;
// fixed D-over-I priority when undefined).
// Ports (each master/slave has raddr, rdata, waddr, wdata channels with
// *_valid, *_ready and a bus_width data/address field):
//   clk, rst      clock and synchronous active-high reset
//   i_*           instruction master
//   d_*           data master
//   m_*           shared slave (directions mirrored)
module native_bus_arbiter
  import native_bus_pkg::*;
#(
  parameter int unsigned bus_width = 32
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 i_raddr_valid,
  output logic                 i_raddr_ready,
  input  logic [bus_width-1:0] i_raddr,
  output logic                 i_rdata_valid,
  input  logic                 i_rdata_ready,
  output logic [bus_width-1:0] i_rdata,
  input  logic                 i_waddr_valid,
  output logic                 i_waddr_ready,
  input  logic [bus_width-1:0] i_waddr,
  input  logic                 i_wdata_valid,
  output logic                 i_wdata_ready,
  input  logic [bus_width-1:0] i_wdata,

  input  logic                 d_raddr_valid,
  output logic                 d_raddr_ready,
  input  logic [bus_width-1:0] d_raddr,
  output logic                 d_rdata_valid,
  input  logic                 d_rdata_ready,
  output logic [bus_width-1:0] d_rdata,
  input  logic                 d_waddr_valid,
  output logic                 d_waddr_ready,
  input  logic [bus_width-1:0] d_waddr,
  input  logic                 d_wdata_valid,
  output logic                 d_wdata_ready,
  input  logic [bus_width-1:0] d_wdata,

  output logic                 m_raddr_valid,
  input  logic                 m_raddr_ready,
  output logic [bus_width-1:0] m_raddr,
  input  logic                 m_rdata_valid,
  output logic                 m_rdata_ready,
  input  logic [bus_width-1:0] m_rdata,
  output logic                 m_waddr_valid,
  input  logic                 m_waddr_ready,
  output logic [bus_width-1:0] m_waddr,
  output logic                 m_wdata_valid,
  input  logic                 m_wdata_ready,
  output logic [bus_width-1:0] m_wdata
);

  rstate_t rstate;
  wstate_t wstate;
  logic    rgrant, wgrant;
  logic    waddr_done, wdata_done;
  logic    r_last, w_last;
  logic    r_win, r_win_valid, w_win, w_win_valid;
  logic    rsel, wsel;
  logic    r_addr_ph, r_data_ph, aw_open, w_open;
  logic    own_raddr_valid, own_rdata_ready, own_waddr_valid, own_wdata_valid;
  logic    ar_hs, r_hs, aw_hs, w_hs;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef NATIVE_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= MST_I;
      w_last <= MST_I;
    end else begin
      if (r_win_valid) r_last <= r_win;
      if (w_win_valid) w_last <= w_win;
    end
  end
`else
  assign r_last = MST_I;
  assign w_last = MST_I;
`endif

  native_rr_arbiter u_rd_arb (
    .req         ({d_raddr_valid, i_raddr_valid}),
    .enable      (rstate == R_IDLE),
    .last        (r_last),
    .grant_valid (r_win_valid),
    .grant       (r_win)
  );

  native_rr_arbiter u_wr_arb (
    .req         ({d_waddr_valid | d_wdata_valid, i_waddr_valid | i_wdata_valid}),
    .enable      (wstate == W_IDLE),
    .last        (w_last),
    .grant_valid (w_win_valid),
    .grant       (w_win)
  );

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rstate <= R_IDLE;
      rgrant <= MST_D;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (r_win_valid) begin
            rgrant <= r_win;
            rstate <= R_ADDR;
          end
        end
        R_ADDR:  if (ar_hs) rstate <= R_DATA;
        R_DATA:  if (r_hs) rstate <= R_IDLE;
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wstate     <= W_IDLE;
      wgrant     <= MST_D;
      waddr_done <= 1'b0;
      wdata_done <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (w_win_valid) begin
            wgrant     <= w_win;
            waddr_done <= 1'b0;
            wdata_done <= 1'b0;
            wstate     <= W_XFER;
          end
        end
        W_XFER: begin
          if (aw_hs) waddr_done <= 1'b1;
          if (w_hs)  wdata_done <= 1'b1;
          // Both channels may finish in either order or together.
          if ((waddr_done | aw_hs) & (wdata_done | w_hs)) wstate <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Routing. Idle states select D for the data muxes and drive no handshake
  // signals, so no valid->ready path exists there. Reset forces all outputs 0.
  // ---------------------------------------------------------------------------
  assign rsel      = (rstate == R_IDLE) ? MST_D : rgrant;
  assign wsel      = (wstate == W_IDLE) ? MST_D : wgrant;
  assign r_addr_ph = (rstate == R_ADDR);
  assign r_data_ph = (rstate == R_DATA);
  assign aw_open   = (wstate == W_XFER) & ~waddr_done;
  assign w_open    = (wstate == W_XFER) & ~wdata_done;

  assign own_raddr_valid = (rsel == MST_D) ? d_raddr_valid : i_raddr_valid;
  assign own_rdata_ready = (rsel == MST_D) ? d_rdata_ready : i_rdata_ready;
  assign own_waddr_valid = (wsel == MST_D) ? d_waddr_valid : i_waddr_valid;
  assign own_wdata_valid = (wsel == MST_D) ? d_wdata_valid : i_wdata_valid;

  assign m_raddr_valid = ~rst & r_addr_ph & own_raddr_valid;
  assign m_rdata_ready = ~rst & r_data_ph & own_rdata_ready;
  assign m_waddr_valid = ~rst & aw_open & own_waddr_valid;
  assign m_wdata_valid = ~rst & w_open & own_wdata_valid;

  assign m_raddr = rst ? '0 : ((rsel == MST_D) ? d_raddr : i_raddr);
  assign m_waddr = rst ? '0 : ((wsel == MST_D) ? d_waddr : i_waddr);
  assign m_wdata = rst ? '0 : ((wsel == MST_D) ? d_wdata : i_wdata);

  assign i_raddr_ready = ~rst & r_addr_ph & (rsel == MST_I) & m_raddr_ready;
  assign d_raddr_ready = ~rst & r_addr_ph & (rsel == MST_D) & m_raddr_ready;
  assign i_rdata_valid = ~rst & r_data_ph & (rsel == MST_I) & m_rdata_valid;
  assign d_rdata_valid = ~rst & r_data_ph & (rsel == MST_D) & m_rdata_valid;
  assign i_rdata       = (rst | (rsel != MST_I)) ? '0 : m_rdata;
  assign d_rdata       = (rst | (rsel != MST_D)) ? '0 : m_rdata;

  assign i_waddr_ready = ~rst & aw_open & (wsel == MST_I) & m_waddr_ready;
  assign d_waddr_ready = ~rst & aw_open & (wsel == MST_D) & m_waddr_ready;
  assign i_wdata_ready = ~rst & w_open & (wsel == MST_I) & m_wdata_ready;
  assign d_wdata_ready = ~rst & w_open & (wsel == MST_D) & m_wdata_ready;

  assign ar_hs = m_raddr_valid & m_raddr_ready;
  assign r_hs  = m_rdata_valid & m_rdata_ready;
  assign aw_hs = m_waddr_valid & m_waddr_ready;
  assign w_hs  = m_wdata_valid & m_wdata_ready;

endmodule

// File: tb/tb_native_bus_arbiter.sv
// Self-checking bench for native_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model (owner / phase / done flags per direction).
module tb_native_bus_arbiter;

  localparam int BW = 32;
`ifdef NATIVE_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  logic i_raddr_valid, i_raddr_ready, i_rdata_valid, i_rdata_ready;
  logic i_waddr_valid, i_waddr_ready, i_wdata_valid, i_wdata_ready;
  logic [BW-1:0] i_raddr, i_rdata, i_waddr, i_wdata;
  logic d_raddr_valid, d_raddr_ready, d_rdata_valid, d_rdata_ready;
  logic d_waddr_valid, d_waddr_ready, d_wdata_valid, d_wdata_ready;
  logic [BW-1:0] d_raddr, d_rdata, d_waddr, d_wdata;
  logic m_raddr_valid, m_raddr_ready, m_rdata_valid, m_rdata_ready;
  logic m_waddr_valid, m_waddr_ready, m_wdata_valid, m_wdata_ready;
  logic [BW-1:0] m_raddr, m_rdata, m_waddr, m_wdata;

  always #5 clk = ~clk;

  native_bus_arbiter #(.bus_width(BW)) dut (
    .clk(clk), .rst(rst),
    .i_raddr_valid(i_raddr_valid), .i_raddr_ready(i_raddr_ready), .i_raddr(i_raddr),
    .i_rdata_valid(i_rdata_valid), .i_rdata_ready(i_rdata_ready), .i_rdata(i_rdata),
    .i_waddr_valid(i_waddr_valid), .i_waddr_ready(i_waddr_ready), .i_waddr(i_waddr),
    .i_wdata_valid(i_wdata_valid), .i_wdata_ready(i_wdata_ready), .i_wdata(i_wdata),
    .d_raddr_valid(d_raddr_valid), .d_raddr_ready(d_raddr_ready), .d_raddr(d_raddr),
    .d_rdata_valid(d_rdata_valid), .d_rdata_ready(d_rdata_ready), .d_rdata(d_rdata),
    .d_waddr_valid(d_waddr_valid), .d_waddr_ready(d_waddr_ready), .d_waddr(d_waddr),
    .d_wdata_valid(d_wdata_valid), .d_wdata_ready(d_wdata_ready), .d_wdata(d_wdata),
    .m_raddr_valid(m_raddr_valid), .m_raddr_ready(m_raddr_ready), .m_raddr(m_raddr),
    .m_rdata_valid(m_rdata_valid), .m_rdata_ready(m_rdata_ready), .m_rdata(m_rdata),
    .m_waddr_valid(m_waddr_valid), .m_waddr_ready(m_waddr_ready), .m_waddr(m_waddr),
    .m_wdata_valid(m_wdata_valid), .m_wdata_ready(m_wdata_ready), .m_wdata(m_wdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] ctrl_now();
    return {i_raddr_ready, i_rdata_valid, i_waddr_ready, i_wdata_ready,
            d_raddr_ready, d_rdata_valid, d_waddr_ready, d_wdata_ready,
            m_raddr_valid, m_rdata_ready, m_waddr_valid, m_wdata_valid};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: owner -1 means idle, 0 = I, 1 = D.
  // ---------------------------------------------------------------------------
  int r_own = -1, w_own = -1;
  bit r_dat, aw_dn, w_dn, last_r, last_w;

  function automatic int pick(bit req_i, bit req_d, bit last);
    if (req_i && req_d) return (RR && last) ? 0 : 1;
    if (req_d) return 1;
    if (req_i) return 0;
    return -1;
  endfunction

  function automatic logic of1(int who, logic a_i, logic a_d);
    return (who == 1) ? a_d : a_i;
  endfunction

  function automatic logic [31:0] of32(int who, logic [31:0] a_i, logic [31:0] a_d);
    return (who == 1) ? a_d : a_i;
  endfunction

  task automatic model_step();
    int g;
    if (rst) begin
      r_own = -1; r_dat = 0; w_own = -1; aw_dn = 0; w_dn = 0; last_r = 0; last_w = 0;
    end else begin
      if (r_own < 0) begin
        g = pick(i_raddr_valid, d_raddr_valid, last_r);
        if (g >= 0) begin r_own = g; r_dat = 0; last_r = (g == 1); end
      end else if (!r_dat) begin
        if (of1(r_own, i_raddr_valid, d_raddr_valid) && m_raddr_ready) r_dat = 1;
      end else if (m_rdata_valid && of1(r_own, i_rdata_ready, d_rdata_ready)) begin
        r_own = -1;
      end
      if (w_own < 0) begin
        g = pick(i_waddr_valid | i_wdata_valid, d_waddr_valid | d_wdata_valid, last_w);
        if (g >= 0) begin w_own = g; aw_dn = 0; w_dn = 0; last_w = (g == 1); end
      end else begin
        if (!aw_dn && of1(w_own, i_waddr_valid, d_waddr_valid) && m_waddr_ready) aw_dn = 1;
        if (!w_dn && of1(w_own, i_wdata_valid, d_wdata_valid) && m_wdata_ready) w_dn = 1;
        if (aw_dn && w_dn) w_own = -1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Handshake monitors used by the directed scenarios.
  logic [31:0] rd_log[$];
  int aw_cnt = 0, w_cnt = 0;

  task automatic compare();
    logic e_irr, e_irv, e_iaw, e_iw, e_drr, e_drv, e_daw, e_dw;
    logic e_mar, e_mrr, e_maw, e_mw;
    if (rst) begin
      chk("rst_ctrl", {20'd0, ctrl_now()}, 32'd0);
      chk("rst_data", i_rdata | d_rdata | m_raddr | m_waddr | m_wdata, 32'd0);
      return;
    end
    {e_irr, e_irv, e_iaw, e_iw, e_drr, e_drv, e_daw, e_dw} = '0;
    {e_mar, e_mrr, e_maw, e_mw} = '0;
    if (r_own >= 0 && !r_dat) begin
      e_mar = of1(r_own, i_raddr_valid, d_raddr_valid);
      if (r_own == 1) e_drr = m_raddr_ready; else e_irr = m_raddr_ready;
    end
    if (r_own >= 0 && r_dat) begin
      e_mrr = of1(r_own, i_rdata_ready, d_rdata_ready);
      if (r_own == 1) e_drv = m_rdata_valid; else e_irv = m_rdata_valid;
    end
    if (w_own >= 0 && !aw_dn) begin
      e_maw = of1(w_own, i_waddr_valid, d_waddr_valid);
      if (w_own == 1) e_daw = m_waddr_ready; else e_iaw = m_waddr_ready;
    end
    if (w_own >= 0 && !w_dn) begin
      e_mw = of1(w_own, i_wdata_valid, d_wdata_valid);
      if (w_own == 1) e_dw = m_wdata_ready; else e_iw = m_wdata_ready;
    end
    chk("model_ctrl", {20'd0, ctrl_now()},
        {20'd0, e_irr, e_irv, e_iaw, e_iw, e_drr, e_drv, e_daw, e_dw,
         e_mar, e_mrr, e_maw, e_mw});
    if (e_mar) chk("model_m_raddr", m_raddr, of32(r_own, i_raddr, d_raddr));
    if (e_maw) chk("model_m_waddr", m_waddr, of32(w_own, i_waddr, d_waddr));
    if (e_mw)  chk("model_m_wdata", m_wdata, of32(w_own, i_wdata, d_wdata));
    if (e_irv) chk("model_i_rdata", i_rdata, m_rdata);
    if (e_drv) chk("model_d_rdata", d_rdata, m_rdata);
    if (m_raddr_valid && m_raddr_ready) rd_log.push_back(m_raddr);
    if (m_waddr_valid && m_waddr_ready) aw_cnt++;
    if (m_wdata_valid && m_wdata_ready) w_cnt++;
  endtask

  initial forever begin
    @(negedge clk);
    compare();
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    {i_raddr_valid, i_rdata_ready, i_waddr_valid, i_wdata_valid} = '0;
    {d_raddr_valid, d_rdata_ready, d_waddr_valid, d_wdata_valid} = '0;
    {m_raddr_ready, m_rdata_valid, m_waddr_ready, m_wdata_ready} = '0;
    {i_raddr, i_waddr, i_wdata, d_raddr, d_waddr, d_wdata, m_rdata} = '0;
  endtask

  logic [31:0] i_q[$], d_q[$];

  // Each master presents its queued read addresses back to back; the slave is
  // always ready and returns data in the first data cycle.
  task automatic run_reads();
    int  c;
    logic hi, hd;
    c = 0;
    rd_log.delete();
    m_raddr_ready = 1; m_rdata_valid = 1; i_rdata_ready = 1; d_rdata_ready = 1;
    i_raddr_valid = (i_q.size() > 0);
    if (i_q.size() > 0) i_raddr = i_q[0];
    d_raddr_valid = (d_q.size() > 0);
    if (d_q.size() > 0) d_raddr = d_q[0];
    while ((i_raddr_valid || d_raddr_valid) && c < 60) begin
      at_neg();
      hi = i_raddr_valid & i_raddr_ready;
      hd = d_raddr_valid & d_raddr_ready;
      step();
      if (hi) begin
        void'(i_q.pop_front());
        i_raddr_valid = (i_q.size() > 0);
        if (i_q.size() > 0) i_raddr = i_q[0];
      end
      if (hd) begin
        void'(d_q.pop_front());
        d_raddr_valid = (d_q.size() > 0);
        if (d_q.size() > 0) d_raddr = d_q[0];
      end
      c++;
    end
    chk("rd_loop_bound", (c < 60) ? 32'd1 : 32'd0, 32'd1);
    step();
    step();
    idle_inputs();
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int aw0, w0;
    rst = 1;
    idle_inputs();
    repeat (2) step();
    at_neg();
    chk("reset_ctrl", {20'd0, ctrl_now()}, 32'd0);
    step();
    rst = 0;
    step();

    // Single read by I, data returned on the second data cycle.
    i_raddr_valid = 1; i_raddr = 32'h100; m_raddr_ready = 1;
    at_neg();
    chk("sr_arb_no_ready", i_raddr_ready, 0);
    step();
    at_neg();
    chk("sr_addr_valid", m_raddr_valid, 1);
    chk("sr_addr", m_raddr, 32'h100);
    chk("sr_i_ready", i_raddr_ready, 1);
    step();
    i_raddr_valid = 0; i_rdata_ready = 1; m_rdata_valid = 0;
    at_neg();
    chk("sr_wait_valid", i_rdata_valid, 0);
    chk("sr_m_rdata_ready", m_rdata_ready, 1);
    step();
    m_rdata_valid = 1; m_rdata = 32'hDEADBEEF;
    at_neg();
    chk("sr_i_rdata_valid", i_rdata_valid, 1);
    chk("sr_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("sr_d_rdata_valid", d_rdata_valid, 0);
    step();
    idle_inputs();
    at_neg();
    chk("sr_done", i_rdata_valid, 0);
    step();

    // Simultaneous reads; D re-requests, forming a second tie.
    i_q = '{32'h10};
    d_q = '{32'h20, 32'h24};
    run_reads();
    chk("tie_count", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      chk("tie_first", rd_log[0], 32'h20);
      chk("tie_second", rd_log[1], RR ? 32'h10 : 32'h24);
      chk("tie_third", rd_log[2], RR ? 32'h24 : 32'h10);
    end

    // Split write: data two cycles ahead of address, data valid held high.
    aw0 = aw_cnt; w0 = w_cnt;
    d_wdata_valid = 1; d_wdata = 32'h55; m_waddr_ready = 1; m_wdata_ready = 1;
    at_neg();
    chk("sw_idle_ready", d_wdata_ready, 0);
    step();
    at_neg();
    chk("sw_wdata_valid", m_wdata_valid, 1);
    chk("sw_wdata", m_wdata, 32'h55);
    chk("sw_wdata_ready", d_wdata_ready, 1);
    chk("sw_no_waddr", m_waddr_valid, 0);
    step();
    d_waddr_valid = 1; d_waddr = 32'h40;
    at_neg();
    chk("sw_wdata_masked", m_wdata_valid, 0);
    chk("sw_wdata_ready_masked", d_wdata_ready, 0);
    chk("sw_waddr_valid", m_waddr_valid, 1);
    chk("sw_waddr", m_waddr, 32'h40);
    step();
    d_waddr_valid = 0; d_wdata_valid = 0;
    at_neg();
    chk("sw_idle_again", {30'd0, d_wdata_ready, m_waddr_valid}, 32'd0);
    chk("sw_aw_count", aw_cnt - aw0, 1);
    chk("sw_w_count", w_cnt - w0, 1);
    step();
    idle_inputs();

    // Concurrent read by I and write by D.
    i_raddr_valid = 1; i_raddr = 32'h0; i_rdata_ready = 1;
    d_waddr_valid = 1; d_waddr = 32'h8; d_wdata_valid = 1; d_wdata = 32'hAA;
    m_raddr_ready = 1; m_waddr_ready = 1; m_wdata_ready = 1;
    m_rdata_valid = 1; m_rdata = 32'h12345678;
    step();
    at_neg();
    chk("cc_raddr_valid", m_raddr_valid, 1);
    chk("cc_raddr", m_raddr, 32'h0);
    chk("cc_waddr_valid", m_waddr_valid, 1);
    chk("cc_waddr", m_waddr, 32'h8);
    chk("cc_wdata_valid", m_wdata_valid, 1);
    chk("cc_wdata", m_wdata, 32'hAA);
    chk("cc_ready", {29'd0, i_raddr_ready, d_waddr_ready, d_wdata_ready}, 32'd7);
    step();
    i_raddr_valid = 0; d_waddr_valid = 0; d_wdata_valid = 0;
    at_neg();
    chk("cc_rdata_valid", i_rdata_valid, 1);
    chk("cc_rdata", i_rdata, 32'h12345678);
    chk("cc_write_idle", m_waddr_valid, 0);
    step();
    idle_inputs();
    step();

    // Backpressure on I's read data while D waits.
    i_raddr_valid = 1; i_raddr = 32'h30; m_raddr_ready = 1;
    m_rdata_valid = 1; m_rdata = 32'h0BADF00D; i_rdata_ready = 0;
    step();
    d_raddr_valid = 1; d_raddr = 32'h34;
    at_neg();
    chk("bp_addr", m_raddr, 32'h30);
    step();
    i_raddr_valid = 0;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("bp_m_rdata_ready", m_rdata_ready, 0);
      chk("bp_d_not_granted", {30'd0, d_raddr_ready, m_raddr_valid}, 32'd0);
      step();
    end
    i_rdata_ready = 1;
    at_neg();
    chk("bp_release", m_rdata_ready, 1);
    step();
    i_rdata_ready = 0;
    at_neg();
    chk("bp_arb_cycle", m_raddr_valid, 0);
    step();
    at_neg();
    chk("bp_d_addr_valid", m_raddr_valid, 1);
    chk("bp_d_addr", m_raddr, 32'h34);
    chk("bp_d_ready", d_raddr_ready, 1);
    step();
    d_raddr_valid = 0; d_rdata_ready = 1;
    at_neg();
    chk("bp_d_rdata", d_rdata, 32'h0BADF00D);
    step();
    idle_inputs();
    step();

    // Reset while read is in R_DATA and write is stalled in W_XFER.
    i_raddr_valid = 1; i_raddr = 32'h80; m_raddr_ready = 1;
    d_waddr_valid = 1; d_waddr = 32'hC; d_wdata_valid = 1; d_wdata = 32'h77;
    step();
    step();
    rst = 1;
    at_neg();
    chk("rm_ctrl_zero", {20'd0, ctrl_now()}, 32'd0);
    chk("rm_data_zero", i_rdata | d_rdata | m_raddr | m_waddr | m_wdata, 32'd0);
    step();
    rst = 0;
    i_raddr = 32'h200; d_waddr_valid = 0; d_wdata_valid = 0;
    m_rdata_valid = 1; m_rdata = 32'hCAFE0001; i_rdata_ready = 1;
    m_waddr_ready = 1; m_wdata_ready = 1;
    at_neg();
    chk("rm_idle_ctrl", {20'd0, ctrl_now()}, 32'd0);
    step();
    at_neg();
    chk("rm_fresh_addr_valid", m_raddr_valid, 1);
    chk("rm_fresh_addr", m_raddr, 32'h200);
    step();
    i_raddr_valid = 0;
    at_neg();
    chk("rm_fresh_rdata_valid", i_rdata_valid, 1);
    chk("rm_fresh_rdata", i_rdata, 32'hCAFE0001);
    step();
    idle_inputs();
    step();

    // Randomized traffic, checked by the model every cycle.
    for (int n = 0; n < 4000; n++) begin
      rst           = ($urandom_range(0, 199) == 0);
      i_raddr_valid = $urandom_range(0, 1);
      i_rdata_ready = $urandom_range(0, 1);
      i_waddr_valid = $urandom_range(0, 1);
      i_wdata_valid = $urandom_range(0, 1);
      d_raddr_valid = $urandom_range(0, 1);
      d_rdata_ready = $urandom_range(0, 1);
      d_waddr_valid = $urandom_range(0, 1);
      d_wdata_valid = $urandom_range(0, 1);
      m_raddr_ready = $urandom_range(0, 1);
      m_rdata_valid = $urandom_range(0, 1);
      m_waddr_ready = $urandom_range(0, 1);
      m_wdata_ready = $urandom_range(0, 1);
      i_raddr = $urandom; i_waddr = $urandom; i_wdata = $urandom;
      d_raddr = $urandom; d_waddr = $urandom; d_wdata = $urandom;
      m_rdata = $urandom;
      step();
    end
    rst = 0;
    idle_inputs();
    step();
    at_neg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/native_bus_arbiter.md
# native_bus_arbiter

Two-master to one-slave arbiter for the native valid/ready memory bus. It sits between copperv's instruction port (`i_*`) and data port (`d_*`) and a single shared native_memory, so both ports can run from one unified memory. Reads and writes are arbitrated independently, with at most one outstanding transaction per direction. Returning read data is routed back to the master that issued the address.

## Interface
Parameters:
- `bus_width`, 32: address and data width of all channels.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `i_raddr_valid`/`i_raddr_ready`/`i_raddr`  in/out/in  1/1/bus_width  master I read-address channel.
- `i_rdata_valid`/`i_rdata_ready`/`i_rdata`  out/in/out  1/1/bus_width  master I read-data channel.
- `i_waddr_valid`/`i_waddr_ready`/`i_waddr`  in/out/in  1/1/bus_width  master I write-address channel.
- `i_wdata_valid`/`i_wdata_ready`/`i_wdata`  in/out/in  1/1/bus_width  master I write-data channel.
- `d_*`: same twelve signals for master D.
- `m_*`: same twelve signals toward the slave, with directions mirrored (`m_raddr_valid` out, `m_raddr_ready` in, and so on).

## Operation
- A transfer occurs on any channel when valid and ready are both high at a `clk` edge.
- **Read FSM (`R_IDLE`, `R_ADDR`, `R_DATA`):**
  - In `R_IDLE`, if either `*_raddr_valid` is high, register the winner in `rgrant` and go to `R_ADDR`.
  - In `R_ADDR`, the granted master's `raddr_valid`/`raddr` drive `m_raddr_*`, and `m_raddr_ready` is returned to that master only. On the slave handshake, go to `R_DATA`.
  - In `R_DATA`, `m_rdata_valid`/`m_rdata` are routed to the granted master, and that master's `rdata_ready` drives `m_rdata_ready`. On the handshake, go to `R_IDLE`.
- **Write FSM (`W_IDLE`, `W_XFER`):**
  - In `W_IDLE`, a request is a master asserting `waddr_valid` or `wdata_valid`. Register the winner in `wgrant`, clear the `waddr_done`/`wdata_done` flags, and go to `W_XFER`.
  - In `W_XFER`, both of the owner's write channels are forwarded. Each channel's done flag is set on its handshake, and a done channel is masked (valid forced low) afterwards.
  - When both flags are set (either order, or the same cycle), go to `W_IDLE`.
- **Non-granted masters:** all ready outputs low and `rdata_valid` low. `rdata` and the slave address/data are muxed by the grant, with the D master selected when idle.
- **Simultaneous requests:** resolved by the arbitration policy (see Configuration). A lone request always wins.
- **Read and write FSMs are independent:** both may be active at once, and with different owners.
- **Reset:** from any state, both FSMs go to idle, grants go to D, and last-winner state goes to I (so D has priority first). All outputs are 0: every `*_ready`, `*_valid` and `i_rdata`/`d_rdata`/`m_*addr`/`m_wdata` data bus. An in-flight transaction is abandoned.

## Timing
- Arbitration adds 1 cycle. A request seen at edge N appears on `m_raddr_valid`/`m_waddr_valid` after edge N.
- Best-case read: request cycle, then 1 address cycle, then ≥1 data cycle. Next grant is no earlier than the cycle after the rdata handshake, so there is 1 idle cycle between back-to-back reads.
- Best-case write: 2 cycles (grant, then a joint address+data handshake).
- There is no combinational path from `*_valid` to any `*_ready` in the idle states. In granted states, ready passes through combinationally from the slave.

## Configuration
- `NATIVE_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration. A separate last-winner register is kept for reads and for writes, and on a tie the master that did not win last gets the grant.
- Not defined: fixed priority, with D always beating I. The last-winner registers are removed.

## Structure
- Package `native_bus_pkg` holds:
  - read state enum `R_IDLE`/`R_ADDR`/`R_DATA`;
  - write state enum `W_IDLE`/`W_XFER`;
  - master index constants `MST_I=0`, `MST_D=1`.
- Sub-module `native_rr_arbiter`: a 2-way grant (requests, enable, last-winner in; grant out). It is instantiated once per direction and holds the macro-dependent policy.

## Test plan
- **Single read:** I reads 0x100, slave returns 0xDEADBEEF after 2 cycles → only `i_rdata` = 0xDEADBEEF with `i_rdata_valid`; `d_rdata_valid` stays 0.
- **Simultaneous reads:** I at 0x10 and D at 0x20 in the same cycle → D is served first, then I.
  - With the macro, a second tie goes to I, then D.
  - Without the macro, D wins every tie.
- **Split write:** D drives `wdata` 0x55 two cycles before `waddr` 0x40 → exactly one `m_wdata` and one `m_waddr` handshake, FSM returns to `W_IDLE`, and `d_wdata_ready` is not re-asserted.
- **Concurrent read and write:** I reads 0x0 while D writes 0xAA to 0x8 → both complete, slave sees both, and cycle counts match the Timing section.
- **Backpressure:** `i_rdata_ready` held low for 5 cycles in `R_DATA` → `m_rdata_ready` is low and D's pending read is not granted until the I handshake.
- **Reset mid-transfer:** `rst` asserted while in `R_DATA` and `W_XFER` → next cycle all outputs are 0, both FSMs idle, and a fresh read afterwards completes normally.
